// File: rtl/bram_bubble_sorter_p.sv
// In-place bubble sorter that masters a single-port synchronous BRAM while busy.
// Runtime length, ascending/descending, signed/unsigned compare, early exit and abort.
module bram_bubble_sorter_p #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W:0]   len,
   input  logic              descend,
   input  logic              signed_cmp,
   output logic              busy,
   output logic              done,
   output logic [15:0]       pass_count,
   output logic [31:0]       swap_count,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout
);

   typedef enum logic [2:0] {
      IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
   } state_t;

   localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] A_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [ADDR_W-1:0]   p_q;
   logic [ADDR_W-1:0]   last_q;
   logic [DATA_W-1:0]   a_q;
   logic                swapped_q;
   logic                descend_q;
   logic                signed_q;
   logic                abort_pend_q;
   logic [15:0]         pass_q;
   logic [31:0]         swap_q;
   logic                en_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   din_q;

   logic [ADDR_W:0]     p_inc;
   logic                ooo;

   function automatic logic out_of_order(input logic [DATA_W-1:0] x,
                                         input logic [DATA_W-1:0] y,
                                         input logic desc,
                                         input logic sgn);
      logic gt, lt;
      if (sgn) begin
         gt = $signed(x) > $signed(y);
         lt = $signed(x) < $signed(y);
      end else begin
         gt = x > y;
         lt = x < y;
      end
      return desc ? lt : gt;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Widened so p+1 never wraps, even with last at its maximum.
   assign p_inc = {1'b0, p_q} + LEN_ONE;
   assign ooo   = out_of_order(a_q, bram_dout, descend_q, signed_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         p_q          <= '0;
         last_q       <= '0;
         a_q          <= '0;
         swapped_q    <= 1'b0;
         descend_q    <= 1'b0;
         signed_q     <= 1'b0;
         abort_pend_q <= 1'b0;
         pass_q       <= '0;
         swap_q       <= '0;
         en_q         <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
      end else begin
         en_q   <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= '0;
         din_q  <= '0;
         case (state_q)
            IDLE, DONE: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (start) begin
                  pass_q       <= '0;
                  swap_q       <= '0;
                  swapped_q    <= 1'b0;
                  abort_pend_q <= 1'b0;
                  descend_q    <= descend;
                  signed_q     <= signed_cmp;
                  p_q          <= '0;
                  if (len <= LEN_ONE) begin
                     state_q <= DONE;
                  end else begin
                     // len == 2**ADDR_W wraps to all-ones here, which is exactly len-1.
                     last_q  <= len[ADDR_W-1:0] - A_ONE;
                     state_q <= RD_A;
                     en_q    <= 1'b1;
                  end
               end
            end
            RD_A: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= RD_B;
                  en_q    <= 1'b1;
                  addr_q  <= p_inc[ADDR_W-1:0];
               end
            end
            RD_B: begin
               a_q <= bram_dout;
               state_q <= abort ? IDLE : CMP;
            end
            CMP: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (ooo) begin
                  state_q <= WR_A;
                  en_q    <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= p_q;
                  din_q   <= bram_dout;
               end else begin
                  state_q <= NEXT;
               end
            end
            WR_A: begin
               // Abort is deferred so the pair is never left half-swapped.
               swapped_q    <= 1'b1;
               swap_q       <= sat_inc32(swap_q);
               abort_pend_q <= abort;
               state_q      <= WR_B;
               en_q         <= 1'b1;
               we_q         <= 1'b1;
               addr_q       <= p_inc[ADDR_W-1:0];
               din_q        <= a_q;
            end
            WR_B: begin
               abort_pend_q <= 1'b0;
               state_q      <= (abort || abort_pend_q) ? IDLE : NEXT;
            end
            NEXT: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (p_inc < {1'b0, last_q}) begin
                  p_q     <= p_inc[ADDR_W-1:0];
                  state_q <= RD_A;
                  en_q    <= 1'b1;
                  addr_q  <= p_inc[ADDR_W-1:0];
               end else begin
                  pass_q <= sat_inc16(pass_q);
                  if (!swapped_q || last_q == A_ONE) begin
                     state_q <= DONE;
                  end else begin
                     last_q    <= last_q - A_ONE;
                     p_q       <= '0;
                     swapped_q <= 1'b0;
                     state_q   <= RD_A;
                     en_q      <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign done       = (state_q == DONE);
   assign pass_count = pass_q;
   assign swap_count = swap_q;
   assign bram_en    = en_q;
   assign bram_we    = we_q;
   assign bram_addr  = addr_q;
   assign bram_din   = din_q;

endmodule
